// File: rtl/count_display_driver.sv
// count_display_driver
// Shows the live upstream counter value on HEX0 and a decimal wrap count on
// HEX1, both as active-low 7-segment digits. A debounced pushbutton toggles a
// freeze mode that holds both digits. Wrap tracking keeps running while frozen.

module count_display_driver #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WRAP_MAX        = 9
) (
  input  logic       ClockIn,
  input  logic       Clear_b,
  input  logic [3:0] CounterValue,
  input  logic       Tick,
  input  logic       Hold_n,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [3:0] WrapCount,
  output logic       Frozen
);

  // The debounce counter must be able to hold DEBOUNCE_CYCLES itself.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       WRAP_TOP = 4'(WRAP_MAX);

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } freeze_state_t;

  // Button input path
  logic             r_sync1;
  logic             r_sync2;
  logic             r_dbLevel;
  logic             r_dbPrev;
  logic [CNT_W-1:0] r_dbCnt;
  logic             w_press;

  // Freeze control
  freeze_state_t    r_state;
  freeze_state_t    w_nextState;
  logic             w_captureEn;

  // Wrap tracking and display pipeline
  logic             w_wrap;
  logic [3:0]       r_wrapCount;
  logic [3:0]       r_dispVal;
  logic [3:0]       r_dispWrap;
  logic [6:0]       r_hex0;
  logic [6:0]       r_hex1;
  logic [6:0]       w_seg0;
  logic [6:0]       w_seg1;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] segEncode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Two-flop synchronizer for the asynchronous pushbutton; idles high (released).
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Hold_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new button level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_dbLevel <= 1'b1;
      r_dbCnt   <= '0;
    end else if (r_sync2 == r_dbLevel) begin
      r_dbCnt   <= '0;
    end else if (r_dbCnt == CNT_LAST) begin
      r_dbLevel <= r_sync2;
      r_dbCnt   <= '0;
    end else begin
      r_dbCnt   <= r_dbCnt + 1'b1;
    end
  end

  // Remember the previous debounced level so a 1->0 step can be seen as a press.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_dbPrev <= 1'b1;
    end else begin
      r_dbPrev <= r_dbLevel;
    end
  end

  assign w_press = r_dbPrev & ~r_dbLevel;

  // Freeze state register.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_state <= ST_LIVE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Each press flips between live and frozen; capture only happens while live.
  always_comb begin
    w_nextState = r_state;
    w_captureEn = 1'b0;
    case (r_state)
      ST_LIVE: begin
        w_captureEn = 1'b1;
        if (w_press) begin
          w_nextState = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (w_press) begin
          w_nextState = ST_LIVE;
        end
      end
      default: begin
        w_nextState = ST_LIVE;
      end
    endcase
  end

  assign w_wrap = Tick && (CounterValue == 4'hF);

  // Decimal wrap counter; runs regardless of the freeze state.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_wrapCount <= 4'd0;
    end else if (w_wrap) begin
      r_wrapCount <= (r_wrapCount == WRAP_TOP) ? 4'd0 : r_wrapCount + 4'd1;
    end
  end

  // Capture live values while not frozen; the wrap digit takes the pre-update count.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_dispVal  <= 4'd0;
      r_dispWrap <= 4'd0;
    end else if (w_captureEn) begin
      r_dispVal  <= CounterValue;
      r_dispWrap <= r_wrapCount;
    end
  end

  // Segment decode of the captured digits.
  always_comb begin
    w_seg0 = segEncode(r_dispVal);
    w_seg1 = segEncode(r_dispWrap);
  end

  // Registered segment outputs so the displays see glitch-free drive.
  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      r_hex0 <= 7'b1000000;
      r_hex1 <= 7'b1000000;
    end else begin
      r_hex0 <= w_seg0;
      r_hex1 <= w_seg1;
    end
  end

  assign HEX0      = r_hex0;
  assign HEX1      = r_hex1;
  assign WrapCount = r_wrapCount;
  assign Frozen    = (r_state == ST_FROZEN);

endmodule
